// File: rtl/sa_tile_writeback_if.sv
// Stream/BRAM/control bundle for the tile write-back engine.
// master drives control and SA rows; slave is the engine.
interface sa_tile_writeback_if #(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
);
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] cfg_base;
  logic [ADDR_W-1:0] cfg_stride;
  logic [CNT_W-1:0]  cfg_rows;
  logic [CNT_W-1:0]  cfg_tiles;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_din;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  beat_count;
  logic              err_busy;

  modport master (
    output start, abort, cfg_base, cfg_stride, cfg_rows, cfg_tiles, in_valid, in_data,
    input  in_ready, bram_we, bram_addr, bram_din, busy, done, beat_count, err_busy
  );

  modport slave (
    input  start, abort, cfg_base, cfg_stride, cfg_rows, cfg_tiles, in_valid, in_data,
    output in_ready, bram_we, bram_addr, bram_din, busy, done, beat_count, err_busy
  );
endinterface

// File: rtl/sa_tile_writeback.sv
// Writes SA output rows to BRAM at base + row*stride + tile using an adder-only walk.
// One-cycle registered write latency; done coincides with the final write.
module sa_tile_writeback #(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sa_tile_writeback_if.slave   s
);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_stride;
  logic [CNT_W-1:0]  r_rows_m1;
  logic [CNT_W-1:0]  r_tiles_m1;
  logic [CNT_W-1:0]  r_row;
  logic [CNT_W-1:0]  r_tile;
  logic [ADDR_W-1:0] r_row_ptr;
  logic [ADDR_W-1:0] r_tile_ptr;
  logic              r_ready;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_din;
  logic [CNT_W-1:0]  r_beats;

  logic w_accept;
  logic w_last_row;
  logic w_last;
  logic w_zero_geom;

  assign w_accept    = s.in_valid && r_ready;
  assign w_last_row  = (r_row == r_rows_m1);
  assign w_last      = w_last_row && (r_tile == r_tiles_m1);
  assign w_zero_geom = (s.cfg_rows == '0) || (s.cfg_tiles == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_stride   <= '0;
      r_rows_m1  <= '0;
      r_tiles_m1 <= '0;
      r_row      <= '0;
      r_tile     <= '0;
      r_row_ptr  <= '0;
      r_tile_ptr <= '0;
      r_ready    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_din      <= '0;
      r_beats    <= '0;
    end else begin
      r_we   <= w_accept;
      r_done <= 1'b0;
      r_err  <= 1'b0;

      // Beat (t,r) lands at base + r*stride + t: the tile pointer tracks base+t,
      // and each new tile restarts the row pointer one above the previous tile's base.
      if (w_accept) begin
        r_addr  <= r_row_ptr;
        r_din   <= s.in_data;
        r_beats <= r_beats + CNT_W'(1);
        if (w_last_row) begin
          r_row      <= '0;
          r_tile     <= r_tile + CNT_W'(1);
          r_tile_ptr <= r_tile_ptr + ADDR_W'(1);
          r_row_ptr  <= r_tile_ptr + ADDR_W'(1);
        end else begin
          r_row     <= r_row + CNT_W'(1);
          r_row_ptr <= r_row_ptr + r_stride;
        end
      end

      case (r_state)
        IDLE: begin
          if (s.start) begin
            r_stride   <= s.cfg_stride;
            r_rows_m1  <= s.cfg_rows - CNT_W'(1);
            r_tiles_m1 <= s.cfg_tiles - CNT_W'(1);
            r_row      <= '0;
            r_tile     <= '0;
            r_row_ptr  <= s.cfg_base;
            r_tile_ptr <= s.cfg_base;
            r_beats    <= '0;
            r_busy     <= 1'b1;
            if (w_zero_geom) begin
              r_state <= FLUSH;
              r_done  <= 1'b1;
            end else begin
              r_state <= RUN;
              r_ready <= 1'b1;
            end
          end
        end
        RUN: begin
          if (s.start) r_err <= 1'b1;
          if (s.abort) begin
            r_state <= IDLE;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
          end else if (w_accept && w_last) begin
            r_state <= FLUSH;
            r_ready <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        FLUSH: begin
          if (s.start) r_err <= 1'b1;
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign s.in_ready   = r_ready;
  assign s.bram_we    = r_we;
  assign s.bram_addr  = r_addr;
  assign s.bram_din   = r_din;
  assign s.busy       = r_busy;
  assign s.done       = r_done;
  assign s.beat_count = r_beats;
  assign s.err_busy   = r_err;
endmodule

// File: tb/tb_sa_tile_writeback.sv
// Self-checking bench for sa_tile_writeback: job table plus abort/reset sequences,
// with a scoreboard queue of expected BRAM writes filled at each accepted beat.
module tb_sa_tile_writeback;
  localparam int DW = 256;
  localparam int AW = 16;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sa_tile_writeback_if #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dif ();

  sa_tile_writeback #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s     (dif)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct {
    logic [AW-1:0] base;
    logic [AW-1:0] stride;
    logic [CW-1:0] rows;
    logic [CW-1:0] tiles;
    bit            toggle;
    int            exp_beats;
    int            exp_done;
  } vec_t;

  wr_t q[$];
  int  pass_cnt = 0;
  int  total_cnt = 0;
  int  n_done = 0;
  int  n_acc = 0;
  int  n_we = 0;
  bit  pending = 1'b0;

  logic [AW-1:0] m_base, m_stride;
  logic [CW-1:0] m_rows, m_tiles;
  int            m_r, m_t;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Scoreboard: check last cycle's accept, then record this cycle's accept.
  always @(negedge clk) begin
    wr_t e;
    if (!rst_n) begin
      pending = 1'b0;
      q.delete();
    end else begin
      if (dif.bram_we) n_we++;
      if (pending || dif.bram_we) chk("we_timing", dif.bram_we, pending);
      if (pending && dif.bram_we && q.size() > 0) begin
        e = q.pop_front();
        chk("bram_addr", dif.bram_addr, e.addr);
        chk("bram_din", dif.bram_din, e.data);
      end
      if (dif.done) begin
        n_done++;
        if (m_rows != 0 && m_tiles != 0) chk("done_with_last_we", dif.bram_we, 1);
      end
      pending = dif.in_valid && dif.in_ready;
      if (pending) begin
        logic [47:0] a;
        a = 48'(m_base) + 48'(m_r) * 48'(m_stride) + 48'(m_t);
        e.addr = a[AW-1:0];
        e.data = dif.in_data;
        q.push_back(e);
        n_acc++;
        m_r++;
        if (m_r == int'(m_rows)) begin
          m_r = 0;
          m_t++;
        end
      end
    end
  end

  task automatic outputs_zero(input string tag);
    chk({tag, "_we"}, dif.bram_we, 0);
    chk({tag, "_addr"}, dif.bram_addr, 0);
    chk({tag, "_din"}, dif.bram_din, 0);
    chk({tag, "_busy"}, dif.busy, 0);
    chk({tag, "_done"}, dif.done, 0);
    chk({tag, "_ready"}, dif.in_ready, 0);
    chk({tag, "_beats"}, dif.beat_count, 0);
    chk({tag, "_err"}, dif.err_busy, 0);
  endtask

  task automatic start_job(input logic [AW-1:0] b, input logic [AW-1:0] st,
                           input logic [CW-1:0] r, input logic [CW-1:0] t);
    m_base = b; m_stride = st; m_rows = r; m_tiles = t;
    m_r = 0; m_t = 0; n_done = 0; n_acc = 0;
    dif.cfg_base = b; dif.cfg_stride = st; dif.cfg_rows = r; dif.cfg_tiles = t;
    dif.start = 1'b1;
    @(posedge clk); #1;
    dif.start = 1'b0;
  endtask

  task automatic run_job(input vec_t v);
    int cyc;
    bit finished;
    start_job(v.base, v.stride, v.rows, v.tiles);
    finished = 1'b0;
    for (cyc = 0; cyc < 3000; cyc++) begin
      dif.in_valid = v.toggle ? ((cyc % 2) == 0) : 1'b1;
      dif.in_data  = {8{$urandom}};
      @(posedge clk); #1;
      if (!dif.busy) begin
        finished = 1'b1;
        break;
      end
    end
    dif.in_valid = 1'b0;
    chk("job_finished", finished, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("beat_count", dif.beat_count, v.exp_beats);
    chk("done_pulses", n_done, v.exp_done);
    chk("writes_drained", q.size(), 0);
  endtask

  vec_t tbl[6];

  initial begin
    int n_we_snap;
    int guard;
    rst_n = 1'b0;
    dif.start = 0; dif.abort = 0; dif.in_valid = 0; dif.in_data = '0;
    dif.cfg_base = '0; dif.cfg_stride = '0; dif.cfg_rows = '0; dif.cfg_tiles = '0;
    m_base = '0; m_stride = '0; m_rows = '0; m_tiles = '0; m_r = 0; m_t = 0;

    tbl[0] = '{16'd100,  16'd8,  16'd4,  16'd2,  1'b1, 8,   1};
    tbl[1] = '{16'hFFFE, 16'd1,  16'd4,  16'd1,  1'b0, 4,   1};
    tbl[2] = '{16'd0,    16'd0,  16'd0,  16'd5,  1'b0, 0,   1};
    tbl[3] = '{16'd7,    16'd7,  16'd5,  16'd0,  1'b0, 0,   1};
    tbl[4] = '{16'd5,    16'd3,  16'd3,  16'd3,  1'b1, 9,   1};
    tbl[5] = '{16'd0,    16'd24, 16'd16, 16'd24, 1'b0, 384, 1};

    repeat (3) @(posedge clk);
    #1;
    outputs_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) run_job(tbl[i]);

    // Abort after 3 beats with a 4th beat in the abort cycle; busy start in between.
    start_job(16'd0, 16'd10, 16'd4, 16'd2);
    dif.in_valid = 1'b1;
    guard = 0;
    while (n_acc < 1 && guard < 50) begin
      dif.in_data = {8{$urandom}};
      @(posedge clk); #1;
      guard++;
    end
    dif.start = 1'b1;
    dif.cfg_base = 16'd555; dif.cfg_stride = 16'd1; dif.cfg_rows = 16'd1; dif.cfg_tiles = 16'd1;
    @(posedge clk); #1;
    dif.start = 1'b0;
    chk("err_busy_pulse", dif.err_busy, 1);
    @(posedge clk); #1;
    chk("err_busy_one_cycle", dif.err_busy, 0);
    guard = 0;
    while (n_acc < 3 && guard < 50) begin
      dif.in_data = {8{$urandom}};
      @(posedge clk); #1;
      guard++;
    end
    chk("pre_abort_beats", n_acc, 3);
    dif.abort = 1'b1;
    dif.in_data = {8{$urandom}};
    @(posedge clk); #1;
    dif.abort = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    dif.in_valid = 1'b0;
    chk("abort_ready_low", dif.in_ready, 0);
    chk("abort_busy_low", dif.busy, 0);
    chk("abort_beat_count", dif.beat_count, 4);
    chk("abort_accepts", n_acc, 4);
    chk("abort_no_done", n_done, 0);
    chk("abort_writes_drained", q.size(), 0);

    // Reset in the middle of a long job.
    start_job(16'd0, 16'd24, 16'd16, 16'd24);
    dif.in_valid = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    outputs_zero("midjob_reset");
    @(posedge clk); #1;
    n_we_snap = n_we;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("no_we_after_reset", n_we, n_we_snap);
    chk("idle_after_reset", dif.busy, 0);
    dif.in_valid = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/sa_tile_writeback.md
Name: sa_tile_writeback

Overview:
Parametrised write-back engine between the systolic-array output stream and a simple-dual-port result BRAM (write port only). It takes a runtime-configured tile geometry (base, row stride, rows per tile, tile count) and accepts output rows over a valid/ready handshake. Each accepted row is written to base + row*stride + tile, which generalises the fixed-stride column-interleaved layout. It adds backpressure, abort, a beat counter and a busy-start error flag, and signals completion with a done pulse.

Parameters:
DATA_W, 256, width of one SA output row / BRAM word
ADDR_W, 16, BRAM address width; all address arithmetic is modulo 2^ADDR_W
CNT_W, 16, width of the rows, tiles and beat counters

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; latches cfg_* and starts a job when idle
abort  in  1  one-cycle pulse; terminates the current job
cfg_base  in  ADDR_W  first BRAM address
cfg_stride  in  ADDR_W  address increment between consecutive rows of one tile
cfg_rows  in  CNT_W  rows per tile
cfg_tiles  in  CNT_W  number of tiles
in_valid  in  1  SA row valid
in_ready  out  1  engine accepts a row
in_data  in  DATA_W  SA row data
bram_we  out  1  BRAM write enable
bram_addr  out  ADDR_W  BRAM write address
bram_din  out  DATA_W  BRAM write data
busy  out  1  job in progress
done  out  1  one-cycle completion pulse
beat_count  out  CNT_W  beats accepted in the current or last job
err_busy  out  1  one-cycle pulse when start arrives while busy

Behaviour:
- Reset values: all outputs 0, all counters 0, FSM in IDLE. Reset is asynchronous and overrides everything, including a job in progress. No BRAM write occurs after reset assertion.
- FSM states: IDLE, RUN, FLUSH.
- IDLE, on start: latch all cfg_* values and clear beat_count.
  - If cfg_rows==0 or cfg_tiles==0: go to FLUSH with no writes.
  - Otherwise: go to RUN with row=0, tile=0, row_ptr=cfg_base, tile_ptr=cfg_base.
- in_ready = (state==RUN). A beat is accepted on a cycle where in_valid && in_ready.
- On an accepted beat, at the next rising edge:
  - bram_we=1, bram_addr=row_ptr, bram_din=in_data. Latency is 1 cycle, registered.
  - beat_count increments.
- Address walk, using adders only (no multiplier):
  - While row < cfg_rows-1: row_ptr += cfg_stride and row++.
  - At the last row of a tile: tile++, tile_ptr += 1, row_ptr = tile_ptr + 1, row = 0.
  - Net result: beat (t,r) goes to cfg_base + r*cfg_stride + t, modulo 2^ADDR_W. Wrap-around is silent.
- Last beat (row==cfg_rows-1 and tile==cfg_tiles-1): go to FLUSH. in_ready drops the cycle after acceptance.
- FLUSH lasts one cycle: done=1 (coincident with the last bram_we), busy drops, next state is IDLE.
- bram_we is 0 on every cycle without a beat accepted on the previous cycle. in_valid low inserts bubbles with no effect on the address sequence.
- busy = (state != IDLE).
- beat_count holds its final value until the next start.
- start while busy: ignored, err_busy pulses for 1 cycle, config is not re-latched.
- start on the FLUSH cycle: counts as busy and is ignored with err_busy. It is accepted on the following IDLE cycle.
- abort in RUN:
  - Next state is IDLE; in_ready drops next cycle; no done pulse.
  - A beat accepted in the same cycle as abort is still written, one cycle later.
  - beat_count keeps the partial count.
- abort in IDLE: no effect. abort and start in the same IDLE cycle: start wins.
- cfg_* changes while busy have no effect on the running job.

Test Plan:
- Reset mid-job: base=0, stride=24, rows=16, tiles=24, 384 beats, data=i+2, in_valid held 1. Expect addr sequence 0,24,...,360, then 1,25,...; beat i reaches addr (i%16)*24+i/16. done pulses once with the 384th write; beat_count=384. Assert rst_n low mid-job: all outputs 0 immediately, and bram_we stays 0 after release.
- Backpressure: rows=4, tiles=2, stride=8, base=100, in_valid toggled 1-0-1-0. Expect addrs 100,108,116,124,101,109,117,125 with no duplicates or skips; every write lands 1 cycle after its accept.
- Wrap: ADDR_W=16, base=0xFFFE, stride=1, rows=4, tiles=1. Expect addrs FFFE, FFFF, 0000, 0001.
- Zero geometry: rows=0, tiles=5, then start. Expect no bram_we, done 1 cycle later, beat_count=0.
- Abort and busy start: abort after 3 of 8 beats, with a beat accepted in the abort cycle. Expect 4 writes, beat_count=4, no done. A second start while busy gives err_busy=1 for 1 cycle and the job is unchanged.
